mealy_hit_logger: RTL and testbench
===================================

# mealy_hit_logger

Downstream consumer of the Mealy sequence detector's one-cycle `out` pulse. It counts detector hits and timestamps each one with a free-running cycle counter. Timestamps are stored in a small first-word-fall-through FIFO that a host or bench drains with a read strobe. The block provides a hit history for the detector stage without adding any logic inside the detector.

## Interface
Parameters:
- `TS_W`, default 8: timestamp counter width; wraps modulo 2^TS_W.
- `DEPTH`, default 4: number of FIFO entries; must be a power of 2, at least 2.
- `CNT_W`, default 8: width of the hit counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `hit`  in  1: detector output; sampled on every rising edge.
- `enable`  in  1: timestamp and hit capture enable.
- `rd_en`  in  1: pop strobe; pops the head entry when `empty`=0.
- `rd_data`  out  TS_W: head entry; forced to 0 when `empty`=1.
- `empty`  out  1: FIFO holds no entries.
- `full`  out  1: FIFO holds DEPTH entries.
- `level`  out  $clog2(DEPTH)+1: current entry count.
- `hit_count`  out  CNT_W: number of accepted hits.
- `dropped`  out  1: sticky flag; set when a hit arrives while the FIFO is full and no pop occurs.

## Operation
- Timestamp `ts`:
  - Increments by 1 each edge while `enable`=1 and holds while `enable`=0.
  - Wraps from 2^TS_W−1 to 0.
- Hit capture:
  - A hit is accepted on an edge where `hit`=1 and `enable`=1.
  - The value pushed is `ts` as it was before that edge's increment.
  - Each cycle with `hit`=1 counts as one hit; no edge detection. Overlapping detector pulses must each be logged.
- `hit_count` increments on every accepted hit, including hits that are dropped. Behaviour at the maximum value is set by the macro in Configuration.
- FIFO: write pointer and read pointer are each $clog2(DEPTH)+1 bits, i.e. one extra wrap bit.
  - `empty` = the pointers are fully equal.
  - `full` = the index bits are equal and the wrap bits differ.
- Push, pop and simultaneous events on one edge:
  - Push only, not full: entry written, `level` +1.
  - Push only, full: entry discarded, `dropped` set to 1, pointers unchanged.
  - Pop only, not empty: read pointer advances, `level` −1.
  - Pop when empty: ignored, no state change.
  - Push and pop, not empty and not full: both occur, `level` unchanged.
  - Push and pop when full: both occur (the pop frees the slot), `level` stays DEPTH, no drop.
  - Push and pop when empty: the push occurs, the pop is ignored, `level` becomes 1.
- `dropped` clears only on reset.
- Reads do not depend on `enable`; draining is allowed while `enable`=0.
- Reset in mid-operation:
  - Pointers, `ts`, `hit_count` and `dropped` are cleared on the next edge.
  - FIFO contents are abandoned; the storage array itself is not reset.

## Timing
- Reset values of outputs: `rd_data`=0, `empty`=1, `full`=0, `level`=0, `hit_count`=0, `dropped`=0. Internal `ts`=0.
- Capture latency is one edge. For a hit sampled at edge N:
  - `empty`, `level`, `full` and `hit_count` update right after edge N.
  - If the FIFO was empty, `rd_data` shows the new timestamp after edge N.
- Pop latency is one edge. With `rd_en`=1 at edge N, `rd_data` shows the next entry, or 0 if now empty, after edge N.
- `rd_data` is a combinational read of the head entry, muxed with `empty`. All other outputs are registered.
- First post-reset edge with `enable`=1 captures `ts`=0.

## Configuration
- `HIT_COUNT_SAT_EN`:
  - Defined: `hit_count` saturates at 2^CNT_W−1 and ignores further hits.
  - Undefined: `hit_count` wraps to 0 after 2^CNT_W−1.
  - FIFO and `dropped` behaviour are identical in both builds.

## Test plan
All scenarios use TS_W=8, DEPTH=4, CNT_W=8, `enable`=1 from the first post-reset edge (`ts`=0 there) unless stated.
- Reset check: hold `reset` for 2 edges with `hit`=1 -> all outputs at reset values and `ts`=0 after release.
- Single hit: `hit`=1 only at the edge where `ts`=5 -> `rd_data`=5, `level`=1, `hit_count`=1. Then `rd_en` for one edge -> `empty`=1, `rd_data`=0.
- Overflow: hits at `ts`=2,3,4,5,6 with no reads -> `full`=1, `level`=4, `dropped`=1, `hit_count`=5. Draining 4 entries gives 2,3,4,5.
- Simultaneous push and pop when full: FIFO full with [10,11,12,13], `hit`=1 and `rd_en`=1 at `ts`=20 -> `level`=4, `dropped`=0. Contents drain as 11,12,13,20.
- Enable gating and wrap: `enable`=0 for 10 cycles while `hit`=1 -> no entries, `ts` frozen. Then run to `ts`=255 and hit at 255 and 0 -> entries 255,0.
- Counter limit: 260 hits with the FIFO drained each cycle -> `hit_count`=255 with `HIT_COUNT_SAT_EN` defined, 4 without.

Source files
------------

// File: rtl/mealy_hit_logger_if.sv
// Bundle of the hit logger's detector input, capture enable, FIFO read port
// and status outputs. master = host/detector side, slave = logger.
interface mealy_hit_logger_if #(
    parameter int TS_W  = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             hit;
    logic             enable;
    logic             rd_en;
    logic [TS_W-1:0]  rd_data;
    logic             empty;
    logic             full;
    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] hit_count;
    logic             dropped;

    modport master (
        output hit, enable, rd_en,
        input  rd_data, empty, full, level, hit_count, dropped
    );

    modport slave (
        input  hit, enable, rd_en,
        output rd_data, empty, full, level, hit_count, dropped
    );
endinterface

// File: rtl/mealy_hit_logger.sv
// Counts detector hits and logs a free-running timestamp per hit into a FWFT FIFO.
// Optional macro HIT_COUNT_SAT_EN: hit_count saturates instead of wrapping.
module mealy_hit_logger #(
    parameter int TS_W  = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    mealy_hit_logger_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [TS_W-1:0]  ts_reg;
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]    level_reg, level_next;
    logic             empty_reg, empty_next;
    logic             full_reg, full_next;
    logic [CNT_W-1:0] hit_count_reg, hit_count_next;
    logic             dropped_reg;
    logic [TS_W-1:0]  mem [DEPTH];

    logic push, pop, do_push, drop;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push    = bus.hit & bus.enable;
    assign pop     = bus.rd_en & ~empty_reg;
    assign do_push = push & (~full_reg | pop);
    assign drop    = push & full_reg & ~pop;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (do_push) wr_ptr_next = wr_ptr_reg + PW'(1);
        if (pop)     rd_ptr_next = rd_ptr_reg + PW'(1);
        empty_next = (wr_ptr_next == rd_ptr_next);
        full_next  = (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]) &&
                     (wr_ptr_next[AW] != rd_ptr_next[AW]);
        level_next = wr_ptr_next - rd_ptr_next;
    end

    always_comb begin
        hit_count_next = hit_count_reg;
`ifdef HIT_COUNT_SAT_EN
        if (push && (hit_count_reg != {CNT_W{1'b1}}))
            hit_count_next = hit_count_reg + CNT_W'(1);
`else
        if (push)
            hit_count_next = hit_count_reg + CNT_W'(1);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_reg        <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            empty_reg     <= 1'b1;
            full_reg      <= 1'b0;
            hit_count_reg <= '0;
            dropped_reg   <= 1'b0;
        end else begin
            if (bus.enable) ts_reg <= ts_reg + TS_W'(1);
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            level_reg     <= level_next;
            empty_reg     <= empty_next;
            full_reg      <= full_next;
            hit_count_reg <= hit_count_next;
            if (drop) dropped_reg <= 1'b1;
        end
    end

    // Storage is deliberately not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (!reset && do_push)
            mem[wr_ptr_reg[AW-1:0]] <= ts_reg;
    end

    assign bus.rd_data   = empty_reg ? '0 : mem[rd_ptr_reg[AW-1:0]];
    assign bus.empty     = empty_reg;
    assign bus.full      = full_reg;
    assign bus.level     = level_reg;
    assign bus.hit_count = hit_count_reg;
    assign bus.dropped   = dropped_reg;
endmodule

// File: tb/tb_mealy_hit_logger.sv
// Self-checking bench for mealy_hit_logger: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_mealy_hit_logger;
    localparam int TS_W  = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int TS_MOD  = 2 ** TS_W;
    localparam int CNT_MOD = 2 ** CNT_W;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mealy_hit_logger_if #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    mealy_hit_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: timestamps held in a bounded queue.
    int m_q[$];
    int m_ts   = 0;
    int m_cnt  = 0;
    bit m_drop = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input bit r, input bit h, input bit e, input bit p);
        reset      = r;
        bus.hit    = h;
        bus.enable = e;
        bus.rd_en  = p;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_ts   = 0;
            m_cnt  = 0;
            m_drop = 1'b0;
        end else begin
            if (p && m_q.size() > 0) m_q.delete(0);
            if (h && e) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_ts);
                else m_drop = 1'b1;
`ifdef HIT_COUNT_SAT_EN
                m_cnt = (m_cnt == CNT_MOD - 1) ? m_cnt : m_cnt + 1;
`else
                m_cnt = (m_cnt + 1) % CNT_MOD;
`endif
            end
            if (e) m_ts = (m_ts + 1) % TS_MOD;
        end
        #1;
    endtask

    task automatic run(input int n, input bit h, input bit e, input bit p);
        for (int k = 0; k < n; k++) tick(1'b0, h, e, p);
    endtask

    task automatic check_model(input string tag);
        int head;
        head = (m_q.size() > 0) ? m_q[0] : 0;
        chk({tag, ".rd_data"},   32'(bus.rd_data),   32'(head));
        chk({tag, ".empty"},     32'(bus.empty),     32'(m_q.size() == 0));
        chk({tag, ".full"},      32'(bus.full),      32'(m_q.size() == DEPTH));
        chk({tag, ".level"},     32'(bus.level),     32'(m_q.size()));
        chk({tag, ".hit_count"}, 32'(bus.hit_count), 32'(m_cnt));
        chk({tag, ".dropped"},   32'(bus.dropped),   32'(m_drop));
    endtask

    typedef struct {
        bit rst;
        bit hit;
        bit en;
        bit rd;
        int n;
        int rd_data;
        bit empty;
        bit full;
        int level;
        int cnt;
        bit drop;
    } vec_t;

    vec_t vt[9];

    initial begin
        int exp_cnt;
        bus.hit    = 1'b0;
        bus.enable = 1'b0;
        bus.rd_en  = 1'b0;

        // rst hit en rd n | rd_data empty full level cnt drop
        vt[0] = '{1, 1, 1, 0, 2,  0, 1, 0, 0, 0, 0};  // reset with hit asserted
        vt[1] = '{0, 0, 1, 0, 5,  0, 1, 0, 0, 0, 0};  // ts runs 0..4
        vt[2] = '{0, 1, 1, 0, 1,  5, 0, 0, 1, 1, 0};  // single hit at ts=5
        vt[3] = '{0, 0, 1, 1, 1,  0, 1, 0, 0, 1, 0};  // pop to empty
        vt[4] = '{0, 1, 0, 0, 10, 0, 1, 0, 0, 1, 0};  // enable gating, ts frozen at 7
        vt[5] = '{0, 1, 1, 0, 1,  7, 0, 0, 1, 2, 0};  // hit shows frozen ts
        vt[6] = '{0, 1, 1, 1, 1,  8, 0, 0, 1, 3, 0};  // push+pop, mid occupancy
        vt[7] = '{0, 0, 0, 1, 1,  0, 1, 0, 0, 3, 0};  // drain with enable low
        vt[8] = '{0, 1, 1, 1, 1,  9, 0, 0, 1, 4, 0};  // push+pop when empty

        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < vt[i].n; k++) tick(vt[i].rst, vt[i].hit, vt[i].en, vt[i].rd);
            chk($sformatf("vec%0d.rd_data", i),   32'(bus.rd_data),   32'(vt[i].rd_data));
            chk($sformatf("vec%0d.empty", i),     32'(bus.empty),     32'(vt[i].empty));
            chk($sformatf("vec%0d.full", i),      32'(bus.full),      32'(vt[i].full));
            chk($sformatf("vec%0d.level", i),     32'(bus.level),     32'(vt[i].level));
            chk($sformatf("vec%0d.hit_count", i), 32'(bus.hit_count), 32'(vt[i].cnt));
            chk($sformatf("vec%0d.dropped", i),   32'(bus.dropped),   32'(vt[i].drop));
            $display("vec %0d: rst=%0b hit=%0b en=%0b rd=%0b x%0d -> rd_data=%0d level=%0d cnt=%0d",
                     i, vt[i].rst, vt[i].hit, vt[i].en, vt[i].rd, vt[i].n,
                     bus.rd_data, bus.level, bus.hit_count);
        end

        // Overflow: hits at ts 2..6, no reads.
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        run(2, 1'b0, 1'b1, 1'b0);
        run(5, 1'b1, 1'b1, 1'b0);
        chk("ovf.full", 32'(bus.full), 32'd1);
        chk("ovf.level", 32'(bus.level), 32'd4);
        chk("ovf.dropped", 32'(bus.dropped), 32'd1);
        chk("ovf.hit_count", 32'(bus.hit_count), 32'd5);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf.drain%0d", k), 32'(bus.rd_data), 32'(2 + k));
            tick(1'b0, 1'b0, 1'b1, 1'b1);
        end
        chk("ovf.empty", 32'(bus.empty), 32'd1);
        chk("ovf.sticky", 32'(bus.dropped), 32'd1);
        $display("seq overflow: level=%0d cnt=%0d", bus.level, bus.hit_count);

        // Simultaneous push and pop while full.
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        run(10, 1'b0, 1'b1, 1'b0);
        run(4, 1'b1, 1'b1, 1'b0);
        run(6, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        chk("fullpp.level", 32'(bus.level), 32'd4);
        chk("fullpp.full", 32'(bus.full), 32'd1);
        chk("fullpp.dropped", 32'(bus.dropped), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fullpp.drain%0d", k), 32'(bus.rd_data), 32'((k < 3) ? 11 + k : 20));
            tick(1'b0, 1'b0, 1'b1, 1'b1);
        end
        chk("fullpp.empty", 32'(bus.empty), 32'd1);
        $display("seq full push+pop: level=%0d dropped=%0d", bus.level, bus.dropped);

        // Timestamp wrap: hits at ts=255 and ts=0.
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        run(255, 1'b0, 1'b1, 1'b0);
        run(2, 1'b1, 1'b1, 1'b0);
        chk("wrap.level", 32'(bus.level), 32'd2);
        chk("wrap.first", 32'(bus.rd_data), 32'd255);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        chk("wrap.second", 32'(bus.rd_data), 32'd0);
        $display("seq wrap: level=%0d", bus.level);

        // Hit counter limit with continuous draining.
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        run(260, 1'b1, 1'b1, 1'b1);
`ifdef HIT_COUNT_SAT_EN
        exp_cnt = 255;
`else
        exp_cnt = 4;
`endif
        chk("cnt.hit_count", 32'(bus.hit_count), 32'(exp_cnt));
        chk("cnt.level", 32'(bus.level), 32'd1);
        chk("cnt.dropped", 32'(bus.dropped), 32'd0);
        chk("cnt.rd_data", 32'(bus.rd_data), 32'd3);
        $display("seq counter limit: hit_count=%0d", bus.hit_count);

        // Randomized traffic against the reference model, with occasional resets.
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check_model("rnd.reset");
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 199) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 2) == 0);
            check_model($sformatf("rnd%0d", i));
        end
        $display("seq random: 3000 cycles");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
